result_port_monitor: RTL and testbench

- Parametrised successor to the single-program result checker: a synthesizable watcher on the data-memory write bus.
- Snoops stores to a configurable test-port word address and detects the begin symbol.
- Compares each later store, in order, against a run-time-loadable expected-value table, then reports error count, duration, finish and timeout.
- Sits beside the CPU/D-cache on the memory side; one instance serves any test program without re-editing a ROM.

---
 rtl/result_mon_pkg.sv | 22 ++
 rtl/result_exp_table.sv | 27 ++
 rtl/result_port_monitor.sv | 199 +++++++++++++++++++
 tb/tb_result_port_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_mon_pkg.sv
// Shared types and helpers for the result-port monitor: FSM state encoding,
// default begin/end tokens and the byte-lane mapping used to undo little-endian
// ordering on the snooped store data.
package result_mon_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCheck  = 2'b01,
        StReport = 2'b10
    } state_e;

    // Tokens as seen after the byte swap (readable order).
    localparam logic [31:0] DEFAULT_BEGIN_SYM = 32'h0000_0168;
    localparam logic [31:0] DEFAULT_END_SYM   = 32'hFFFF_FD5D;

    // Byte swap as a lane map: output lane `lane` takes input lane nbytes-1-lane.
    function automatic int unsigned byte_swap_lane(input int unsigned lane,
                                                   input int unsigned nbytes);
        return nbytes - 1 - lane;
    endfunction

endpackage

// File: rtl/result_exp_table.sv
// Expected-value table: DEPTH x DATA_W register file with one synchronous write
// port and one combinational read port. Deliberately not reset so a loaded table
// survives a reset of the monitor.
module result_exp_table #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port, no reset on the storage.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/result_port_monitor.sv
// Result-port monitor: snoops data-memory stores to TEST_PORT, starts a run on
// BEGIN_SYM, checks each following store against the expected table and reports
// error count, duration, finish and timeout.
// Optional first-mismatch capture is built when RESULT_MON_FIRST_ERR_EN is defined.
module result_port_monitor
    import result_mon_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 30,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'('hFF),
    parameter logic [DATA_W-1:0] BEGIN_SYM = DATA_W'(DEFAULT_BEGIN_SYM),
    parameter int unsigned       CHECK_NUM = 33,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       ERR_W     = 8,
    parameter int unsigned       DUR_W     = 16,
    parameter int unsigned       TIMEOUT   = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wen,
    input  logic                     exp_wen,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [DATA_W-1:0]        exp_data,
    output logic [ERR_W-1:0]         error_num,
    output logic [DUR_W-1:0]         duration,
    output logic [$clog2(DEPTH):0]   check_cnt,
    output logic                     finish,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [DATA_W-1:0]        first_err_data
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NBYTES = DATA_W / 8;

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(CHECK_NUM);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                held_q;
    logic [ERR_W-1:0]    error_num_q, error_num_d;
    logic [DUR_W-1:0]    duration_q, duration_d;
    logic [CNT_W-1:0]    check_cnt_q, check_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                finish_q, finish_d;
    logic                timeout_q, timeout_d;

    logic [DATA_W-1:0]   data_sw;
    logic [DATA_W-1:0]   exp_rdata;
    logic                accepted;
    logic                hit;
    logic                begin_hit;
    logic                done;
    logic                mismatch;

    for (genvar i = 0; i < NBYTES; i++) begin : g_swap
        assign data_sw[8*i +: 8] = data[8*byte_swap_lane(i, NBYTES) +: 8];
    end

    // A store held over a D-cache stall is accepted only on its first cycle.
    assign accepted  = wen & ~held_q;
    assign hit       = accepted & (addr == TEST_PORT);
    assign begin_hit = hit & (data_sw == BEGIN_SYM);
    assign done      = (check_cnt_q == LAST_CNT);
    assign mismatch  = (data_sw != exp_rdata);

    result_exp_table #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_exp_table (
        .clk   (clk),
        .wen   (exp_wen & (state_q == StIdle)),
        .widx  (exp_idx),
        .wdata (exp_data),
        .ridx  (check_cnt_q[IDX_W-1:0]),
        .rdata (exp_rdata)
    );

    // Stall filter: remembers whether wen was high on the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= 1'b0;
        end else begin
            held_q <= wen;
        end
    end

    // Run state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            error_num_q <= '1;
            duration_q  <= '0;
            check_cnt_q <= '0;
            idle_q      <= '0;
            finish_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            error_num_q <= error_num_d;
            duration_q  <= duration_d;
            check_cnt_q <= check_cnt_d;
            idle_q      <= idle_d;
            finish_q    <= finish_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state: run start, in-order checking, completion and idle timeout.
    always_comb begin
        state_d     = state_q;
        error_num_d = error_num_q;
        duration_d  = duration_q;
        check_cnt_d = check_cnt_q;
        idle_d      = idle_q;
        finish_d    = finish_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (begin_hit) begin
                    state_d     = StCheck;
                    error_num_d = '0;
                    duration_d  = '0;
                    check_cnt_d = '0;
                    idle_d      = '0;
                    timeout_d   = 1'b0;
                end
            end
            StCheck: begin
                if (duration_q != '1) begin
                    duration_d = duration_q + 1'b1;
                end
                // Completion is tested first so it wins over a coincident timeout.
                if (done) begin
                    state_d  = StReport;
                    finish_d = 1'b1;
                end else if (hit) begin
                    idle_d = '0;
                    if (mismatch && (error_num_q != '1)) begin
                        error_num_d = error_num_q + 1'b1;
                    end
                    check_cnt_d = check_cnt_q + 1'b1;
                end else if (idle_q == IDLE_LIMIT) begin
                    state_d   = StReport;
                    finish_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StReport: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign error_num = error_num_q;
    assign duration  = duration_q;
    assign check_cnt = check_cnt_q;
    assign finish    = finish_q;
    assign timeout   = timeout_q;

`ifdef RESULT_MON_FIRST_ERR_EN
    logic [IDX_W-1:0]  first_err_idx_q;
    logic [DATA_W-1:0] first_err_data_q;
    logic              run_start;
    logic              first_capture;

    assign run_start     = (state_q == StIdle) & begin_hit;
    assign first_capture = (state_q == StCheck) & ~done & hit & mismatch &
                           (error_num_q == '0);

    // First mismatch of a run, cleared when a new run starts.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
        end else if (first_capture) begin
            first_err_idx_q  <= check_cnt_q[IDX_W-1:0];
            first_err_data_q <= data_sw;
        end
    end

    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
`else
    assign first_err_idx  = '0;
    assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_result_port_monitor.sv
// Bench for result_port_monitor: directed store sequences, a cycle-count based
// reference model compared every cycle, plus hand-computed end-of-run values.
module tb_result_port_monitor;

    localparam int M_IDLE   = 0;
    localparam int M_CHECK  = 1;
    localparam int M_REPORT = 2;
    localparam int TMO      = 64;

`ifdef RESULT_MON_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        exp_wen;
    logic [5:0]  exp_idx;
    logic [31:0] exp_data;
    logic [7:0]  error_num;
    logic [15:0] duration;
    logic [6:0]  check_cnt;
    logic        finish;
    logic        timeout;
    logic [5:0]  first_err_idx;
    logic [31:0] first_err_data;

    always #5 clk = ~clk;

    result_port_monitor #(
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .data           (data),
        .wen            (wen),
        .exp_wen        (exp_wen),
        .exp_idx        (exp_idx),
        .exp_data       (exp_data),
        .error_num      (error_num),
        .duration       (duration),
        .check_cnt      (check_cnt),
        .finish         (finish),
        .timeout        (timeout),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) begin
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] fib(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return 32'(a);
    endfunction

    // Fibonacci up 0..610, back down 610..0, then the end token.
    function automatic logic [31:0] ref_value(input int i);
        if (i < 16) return fib(i);
        if (i < 32) return fib(31 - i);
        return 32'hFFFF_FD5D;
    endfunction

    // Reference model state (cycle arithmetic instead of counters).
    int          m_state, m_err, m_dur, m_cnt, m_fin, m_tmo, m_fe_idx;
    logic [31:0] m_fe_data;
    bit          m_prev;
    int          cyc, m_start, m_last;
    logic [31:0] mtab [64];
    logic [31:0] want [64];

    // Model advance on each edge, then compare all outputs half a cycle later.
    initial begin
        logic        s_rst, s_wen, s_ewen;
        logic [29:0] s_addr;
        logic [31:0] s_data, s_edata, sw;
        logic [5:0]  s_eidx;
        bit          acc, hit;
        cyc = 0;
        m_prev = 1'b0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_wen = wen; s_addr = addr; s_data = data;
            s_ewen = exp_wen; s_eidx = exp_idx; s_edata = exp_data;
            @(negedge clk);
            cyc++;
            if (s_rst) begin
                m_state = M_IDLE; m_err = 255; m_dur = 0; m_cnt = 0; m_fin = 0; m_tmo = 0;
                m_fe_idx = 0; m_fe_data = '0; m_prev = 1'b0;
            end else begin
                acc = s_wen && !m_prev;
                m_prev = s_wen;
                hit = acc && (s_addr == 30'hFF);
                sw = swap32(s_data);
                case (m_state)
                    M_IDLE: begin
                        if (s_ewen) mtab[s_eidx] = s_edata;
                        if (hit && sw == 32'h0000_0168) begin
                            m_state = M_CHECK; m_start = cyc; m_last = cyc;
                            m_err = 0; m_dur = 0; m_cnt = 0; m_tmo = 0;
                            m_fe_idx = 0; m_fe_data = '0;
                        end
                    end
                    M_CHECK: begin
                        m_dur = (cyc - m_start > 65535) ? 65535 : cyc - m_start;
                        if (m_cnt == 33) begin
                            m_state = M_REPORT; m_fin = 1;
                        end else if (hit) begin
                            if (sw != mtab[m_cnt]) begin
                                if (FE_EN && m_err == 0) begin
                                    m_fe_idx = m_cnt; m_fe_data = sw;
                                end
                                if (m_err < 255) m_err++;
                            end
                            m_cnt++;
                            m_last = cyc;
                        end else if (cyc - m_last >= TMO) begin
                            m_state = M_REPORT; m_fin = 1; m_tmo = 1;
                        end
                    end
                    default: ;
                endcase
            end
            check("error_num", 64'(error_num), 64'(m_err));
            check("duration", 64'(duration), 64'(m_dur));
            check("check_cnt", 64'(check_cnt), 64'(m_cnt));
            check("finish", 64'(finish), 64'(m_fin));
            check("timeout", 64'(timeout), 64'(m_tmo));
            check("first_err_idx", 64'(first_err_idx), 64'(m_fe_idx));
            check("first_err_data", 64'(first_err_data), 64'(m_fe_data));
        end
    end

    task automatic store(input logic [29:0] a, input logic [31:0] v, input int hold,
                         input int gap);
        @(negedge clk);
        addr = a; data = swap32(v); wen = 1'b1;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        wen = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_stores(input int n, input int hold, input int gap, input int bad_a,
                               input int bad_b, input bit interleave);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            if (interleave) store(30'hFE, 32'h0000_0168, hold, gap);
            v = want[i];
            if (i == bad_a || i == bad_b) v = v + 32'd1;
            store(30'hFF, v, hold, gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int n = 0;
        while (finish !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, " finish reached"}, 64'(finish), 64'd1);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; addr = '0; data = '0;
        exp_wen = 1'b0; exp_idx = '0; exp_data = '0;
        for (int i = 0; i < 64; i++) want[i] = ref_value(i);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset error_num", 64'(error_num), 64'hFF);
        check("reset check_cnt", 64'(check_cnt), 64'd0);
        check("reset finish", 64'(finish), 64'd0);

        // Table load in IDLE.
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            exp_wen = 1'b1; exp_idx = 6'(i); exp_data = want[i];
        end
        @(negedge clk);
        exp_wen = 1'b0;

        // T1: clean run, single-cycle stores.
        do_reset();
        store(30'hFF, 32'h0000_0168, 1, 1);
        send_stores(33, 1, 1, -1, -1, 1'b0);
        wait_finish("T1");
        check("T1 error_num", 64'(error_num), 64'd0);
        check("T1 check_cnt", 64'(check_cnt), 64'd33);
        check("T1 duration", 64'(duration), 64'd67);
        check("T1 timeout", 64'(timeout), 64'd0);
        store(30'hFF, 32'h0000_0005, 1, 1);
        repeat (3) @(negedge clk);
        check("T1 frozen check_cnt", 64'(check_cnt), 64'd33);

        // T2: stores 5 and 20 corrupted.
        do_reset();
        store(30'hFF, 32'h0000_0168, 1, 1);
        send_stores(33, 1, 1, 5, 20, 1'b0);
        wait_finish("T2");
        check("T2 error_num", 64'(error_num), 64'd2);
        check("T2 first_err_idx", 64'(first_err_idx), FE_EN ? 64'd5 : 64'd0);
        check("T2 first_err_data", 64'(first_err_data), FE_EN ? 64'd6 : 64'd0);

        // T3: wen held 4 cycles per store; table write attempted during CHECK.
        do_reset();
        store(30'hFF, 32'h0000_0168, 4, 1);
        @(negedge clk);
        exp_wen = 1'b1; exp_idx = 6'd0; exp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        exp_wen = 1'b0;
        send_stores(33, 4, 1, -1, -1, 1'b0);
        wait_finish("T3");
        check("T3 error_num", 64'(error_num), 64'd0);
        check("T3 check_cnt", 64'(check_cnt), 64'd33);

        // T4: stores to 'hFE interleaved.
        do_reset();
        store(30'hFF, 32'h0000_0168, 1, 1);
        send_stores(33, 1, 1, -1, -1, 1'b1);
        wait_finish("T4");
        check("T4 error_num", 64'(error_num), 64'd0);
        check("T4 duration", 64'(duration), 64'd133);

        // T5: 10 stores then silence.
        do_reset();
        store(30'hFF, 32'h0000_0168, 1, 1);
        send_stores(10, 1, 1, -1, -1, 1'b0);
        wait_finish("T5");
        check("T5 timeout", 64'(timeout), 64'd1);
        check("T5 check_cnt", 64'(check_cnt), 64'd10);
        check("T5 duration", 64'(duration), 64'd84);

        // T6: reset mid-run, then rerun without reload; begin and table write together.
        do_reset();
        store(30'hFF, 32'h0000_0168, 1, 1);
        send_stores(12, 1, 1, 3, -1, 1'b0);
        check("T6 pre-reset check_cnt", 64'(check_cnt), 64'd12);
        check("T6 pre-reset error_num", 64'(error_num), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("T6 reset error_num", 64'(error_num), 64'hFF);
        check("T6 reset finish", 64'(finish), 64'd0);
        check("T6 reset check_cnt", 64'(check_cnt), 64'd0);
        rst = 1'b0;
        want[32] = 32'h0000_0042;
        @(negedge clk);
        addr = 30'hFF; data = swap32(32'h0000_0168); wen = 1'b1;
        exp_wen = 1'b1; exp_idx = 6'd32; exp_data = 32'h0000_0042;
        @(negedge clk);
        wen = 1'b0; exp_wen = 1'b0;
        send_stores(33, 1, 1, -1, -1, 1'b0);
        wait_finish("T6");
        check("T6 error_num", 64'(error_num), 64'd0);
        check("T6 check_cnt", 64'(check_cnt), 64'd33);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
